// File: rtl/fixed_attention_residual_add_if.sv
// Stream bundle for the attention residual-add stage: skip input, attention input
// and sum output, each a P-element block with valid/ready handshake.
interface fixed_attention_residual_add_if #(
    parameter int P  = 4,
    parameter int W0 = 8,
    parameter int W1 = 8,
    parameter int WO = 8
);
    logic signed [W0-1:0] data_in_0 [P-1:0];
    logic                 data_in_0_valid;
    logic                 data_in_0_ready;
    logic signed [W1-1:0] data_in_1 [P-1:0];
    logic                 data_in_1_valid;
    logic                 data_in_1_ready;
    logic signed [WO-1:0] data_out_0 [P-1:0];
    logic                 data_out_0_valid;
    logic                 data_out_0_ready;

    modport slave (
        input  data_in_0, data_in_0_valid, data_in_1, data_in_1_valid, data_out_0_ready,
        output data_in_0_ready, data_in_1_ready, data_out_0, data_out_0_valid
    );

    modport master (
        output data_in_0, data_in_0_valid, data_in_1, data_in_1_valid, data_out_0_ready,
        input  data_in_0_ready, data_in_1_ready, data_out_0, data_out_0_valid
    );
endinterface

// File: rtl/fixed_attention_residual_add.sv
// Residual add after attention: buffers the early skip stream in a block FIFO and joins
// it with the attention stream, producing a saturated fixed-point sum per element.
module fixed_attention_residual_add #(
    parameter int DATA_IN_0_PRECISION_0       = 8,
    parameter int DATA_IN_0_PRECISION_1       = 4,
    parameter int DATA_IN_1_PRECISION_0       = 8,
    parameter int DATA_IN_1_PRECISION_1       = 4,
    parameter int DATA_OUT_0_PRECISION_0      = 8,
    parameter int DATA_OUT_0_PRECISION_1      = 4,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 4,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 4,
    parameter int DATA_IN_0_PARALLELISM_DIM_0 = 2,
    parameter int DATA_IN_0_PARALLELISM_DIM_1 = 2,
    parameter int SKIP_FIFO_DEPTH             = 8
) (
    input  logic clk,
    input  logic rst,
    fixed_attention_residual_add_if.slave bus
);
    localparam int P    = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
    localparam int W0   = DATA_IN_0_PRECISION_0;
    localparam int W1   = DATA_IN_1_PRECISION_0;
    localparam int WO   = DATA_OUT_0_PRECISION_0;
    localparam int F0   = DATA_IN_0_PRECISION_1;
    localparam int F1   = DATA_IN_1_PRECISION_1;
    localparam int FO   = DATA_OUT_0_PRECISION_1;
    localparam int F    = (F0 > F1) ? F0 : F1;
    localparam int I0   = W0 - F0;
    localparam int I1   = W1 - F1;
    localparam int IM   = (I0 > I1) ? I0 : I1;
    localparam int SW   = IM + F + 1;
    localparam int SHL  = (FO > F) ? (FO - F) : 0;
    localparam int SHR  = (F > FO) ? (F - FO) : 0;
    localparam int CW0  = SW + SHL;
    localparam int CW   = (CW0 > WO) ? CW0 : (WO + 1);
    localparam int AW   = (SKIP_FIFO_DEPTH > 1) ? $clog2(SKIP_FIFO_DEPTH) : 1;
    localparam int CNTW = $clog2(SKIP_FIFO_DEPTH + 1);

    localparam logic [AW-1:0]          LAST_PTR = AW'(SKIP_FIFO_DEPTH - 1);
    localparam logic [CNTW-1:0]        DEPTH_C  = CNTW'(SKIP_FIFO_DEPTH);
    localparam logic signed [CW-1:0]   SAT_MAX  = {{(CW-WO+1){1'b0}}, {(WO-1){1'b1}}};
    localparam logic signed [CW-1:0]   SAT_MIN  = {{(CW-WO+1){1'b1}}, {(WO-1){1'b0}}};

    logic signed [W0-1:0] r_mem [SKIP_FIFO_DEPTH][P];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [CNTW-1:0]      r_count;
    logic signed [WO-1:0] r_dout [P-1:0];
    logic                 r_dout_valid;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_join_ok;
    logic                 w_fire;
    logic signed [CW-1:0] w_a [P];
    logic signed [CW-1:0] w_b [P];
    logic signed [CW-1:0] w_s [P];
    logic signed [WO-1:0] w_sum [P];

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        logic [AW-1:0] n;
        if (p == LAST_PTR) begin
            n = {AW{1'b0}};
        end else begin
            n = p + AW'(1);
        end
        return n;
    endfunction

    function automatic logic signed [WO-1:0] sat_f(input logic signed [CW-1:0] v);
        logic signed [WO-1:0] res;
        if (v > SAT_MAX) begin
            res = {1'b0, {(WO-1){1'b1}}};
        end else if (v < SAT_MIN) begin
            res = {1'b1, {(WO-1){1'b0}}};
        end else begin
            res = v[WO-1:0];
        end
        return res;
    endfunction

    assign w_full              = (r_count == DEPTH_C);
    assign w_empty             = (r_count == {CNTW{1'b0}});
    assign bus.data_in_0_ready = !w_full && !rst;
    assign w_push              = bus.data_in_0_valid && !w_full && !rst;
    // Popping never frees a slot for a same-cycle push; the skip block must already be stored.
    assign w_join_ok           = !w_empty && !rst && (!r_dout_valid || bus.data_out_0_ready);
    assign bus.data_in_1_ready = w_join_ok;
    assign w_fire              = w_join_ok && bus.data_in_1_valid;

    // Skip block storage, written only on an accepted push
    always_ff @(posedge clk) begin
        if (w_push) begin
            for (int i = 0; i < P; i++) begin
                r_mem[r_wr_ptr][i] <= bus.data_in_0[i];
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CNTW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_fire) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_fire})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Align both operands to the common fraction, add, rescale to the output fraction, saturate
    always_comb begin
        for (int i = 0; i < P; i++) begin
            w_a[i]   = CW'(r_mem[r_rd_ptr][i]) <<< (F - F0);
            w_b[i]   = CW'(bus.data_in_1[i]) <<< (F - F1);
            w_s[i]   = ((w_a[i] + w_b[i]) <<< SHL) >>> SHR;
            w_sum[i] = sat_f(w_s[i]);
        end
    end

    // Output register: load on join, hold while stalled, drop valid once taken
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout_valid <= 1'b0;
            for (int i = 0; i < P; i++) begin
                r_dout[i] <= {WO{1'b0}};
            end
        end else if (w_fire) begin
            r_dout_valid <= 1'b1;
            for (int i = 0; i < P; i++) begin
                r_dout[i] <= w_sum[i];
            end
        end else if (bus.data_out_0_ready) begin
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= r_dout_valid;
        end
    end

    assign bus.data_out_0       = r_dout;
    assign bus.data_out_0_valid = r_dout_valid;
endmodule
